// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit add/subtract controller.
// One shared 4-bit carry-lookahead slice processes one nibble per cycle, LSB nibble first.
module cla_seq_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
    logic               res_valid_q, res_valid_d;
    logic               start_ready_q, start_ready_d;
    logic               busy_q, busy_d;

    logic [3:0]         g, p, c;
    logic               slice_cout;
    logic [3:0]         slice_sum;
    logic [WIDTH-1:0]   b_eff;

    // 4-bit carry-lookahead slice on the low nibbles of the operand shift registers
    always_comb begin
        g    = a_q[3:0] & b_q[3:0];
        p    = a_q[3:0] ^ b_q[3:0];
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & carry_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
        slice_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & carry_q);
        slice_sum  = p ^ c;
    end

    assign b_eff = sub ? ~op_b : op_b;

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = b_eff;
                    carry_d = sub;
                    cnt_d   = '0;
                    a_msb_d = op_a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = {4'b0000, a_q[WIDTH-1:4]};
                b_d     = {4'b0000, b_q[WIDTH-1:4]};
                res_d   = {slice_sum, res_q[WIDTH-1:4]};
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    // The last slice sum becomes the result MSB nibble
                    ovf_d   = (a_msb_q == b_msb_q) && (slice_sum[3] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        res_valid_d   = (state_d == DONE);
        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            a_msb_q       <= 1'b0;
            b_msb_q       <= 1'b0;
            ovf_q         <= 1'b0;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            carry_q       <= carry_d;
            a_q           <= a_d;
            b_q           <= b_d;
            res_q         <= res_d;
            a_msb_q       <= a_msb_d;
            b_msb_q       <= b_msb_d;
            ovf_q         <= ovf_d;
            res_valid_q   <= res_valid_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign result      = res_q;
    assign carry_out   = carry_q;
    assign overflow    = ovf_q;
    assign res_valid   = res_valid_q;
    assign start_ready = start_ready_q;
    assign busy        = busy_q;

endmodule
